// File: rtl/sounder_tx_player.sv
// Waveform playback engine: streams a stored period from block RAM over AXI-Stream.
// Plays a fixed number of periods or runs continuously until stopped.
module sounder_tx_player #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic [AWIDTH-1:0] len_m1,
   input  logic [15:0]       num_periods,
   input  logic              start,
   input  logic              stop,
   output logic [DWIDTH-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              busy,
   output logic              period_done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_q;
   logic [DWIDTH-1:0] mem_q [2**AWIDTH];
   logic [DWIDTH-1:0] rdata_q;
   logic              rvld_q;
   logic              rlast_q;
   logic [AWIDTH-1:0] len_q;
   logic [AWIDTH-1:0] raddr_q;
   logic [15:0]       num_q;
   logic [15:0]       rper_q;
   logic [15:0]       per_cnt_q;
   logic              arm_q;
   logic              stop_q;
   logic              pd_q;
   logic [DWIDTH-1:0] fd_q [2];
   logic [1:0]        fl_q;
   logic              wp_q;
   logic              rp_q;
   logic [1:0]        cnt_q;

   logic              pop;
   logic              rd_last;
   logic [2:0]        occ;
   logic              rd_go;
   logic              fin;

   // Credit counts the slot freed by a same-cycle pop so the stream stays gap-free
   always_comb begin
      pop     = (cnt_q != 2'd0) && m_tready;
      rd_last = (raddr_q == len_q);
      occ     = {1'b0, cnt_q} + {2'b0, rvld_q} - {2'b0, pop};
      rd_go   = (state_q == RUN) && arm_q && (occ < 3'd2);
      fin     = rd_go && rd_last &&
                (((num_q != 16'd0) && (rper_q == num_q - 16'd1)) || stop_q || stop);
   end

   assign m_tvalid    = (cnt_q != 2'd0);
   assign m_tdata     = fd_q[rp_q];
   assign m_tlast     = m_tvalid && fl_q[rp_q];
   assign busy        = (state_q != IDLE);
   assign period_done = pd_q;

   // Block RAM: contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en && (state_q == IDLE))
         mem_q[wr_addr] <= wr_data;
      if (rd_go)
         rdata_q <= mem_q[raddr_q];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rvld_q    <= 1'b0;
         rlast_q   <= 1'b0;
         len_q     <= '0;
         raddr_q   <= '0;
         num_q     <= '0;
         rper_q    <= '0;
         per_cnt_q <= '0;
         arm_q     <= 1'b0;
         stop_q    <= 1'b0;
         pd_q      <= 1'b0;
         fd_q[0]   <= '0;
         fd_q[1]   <= '0;
         fl_q      <= '0;
         wp_q      <= 1'b0;
         rp_q      <= 1'b0;
         cnt_q     <= '0;
      end else begin
         pd_q   <= pop && m_tlast;
         rvld_q <= rd_go;
         if (rd_go)
            rlast_q <= rd_last;
         if (pop && m_tlast)
            per_cnt_q <= per_cnt_q + 16'd1;
         if (rvld_q) begin
            fd_q[wp_q] <= rdata_q;
            fl_q[wp_q] <= rlast_q;
            wp_q       <= ~wp_q;
         end
         if (pop)
            rp_q <= ~rp_q;
         cnt_q <= cnt_q + {1'b0, rvld_q} - {1'b0, pop};
         unique case (state_q)
            IDLE: begin
               if (start && !stop) begin
                  state_q   <= RUN;
                  len_q     <= len_m1;
                  num_q     <= num_periods;
                  raddr_q   <= '0;
                  rper_q    <= '0;
                  per_cnt_q <= '0;
                  arm_q     <= 1'b0;
                  stop_q    <= 1'b0;
               end
            end
            RUN: begin
               arm_q <= 1'b1;
               if (stop)
                  stop_q <= 1'b1;
               if (rd_go) begin
                  raddr_q <= rd_last ? '0 : raddr_q + 1'b1;
                  if (rd_last)
                     rper_q <= rper_q + 16'd1;
               end
               if (fin)
                  state_q <= DRAIN;
            end
            DRAIN: begin
               if ((cnt_q == 2'd0) && !rvld_q)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sounder_tx_player.sv
// Scoreboard bench for sounder_tx_player: expected samples are queued from a
// memory model at start; a negedge monitor pops and compares each transfer.
module tb_sounder_tx_player;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;
   logic [9:0]  len_m1;
   logic [15:0] num_periods;
   logic        start;
   logic        stop;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic        busy;
   logic        period_done;

   always #5 clk = ~clk;

   sounder_tx_player #(.DWIDTH(32), .AWIDTH(10)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .len_m1(len_m1), .num_periods(num_periods),
      .start(start), .stop(stop), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
      .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy),
      .period_done(period_done)
   );

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mdl [1024];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          first_x = 0;
   int          last_x = 0;
   int          n_x = 0;
   int          n_pd = 0;
   bit          rnd_rdy = 1'b0;
   logic        prev_stall = 1'b0;
   logic        prev_tlx = 1'b0;
   logic [31:0] held_d;
   logic        held_l;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Ready changes just after the active edge
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_tready = !rnd_rdy || ($urandom_range(0, 1) == 1);
      end
   end

   // Monitor: compares every transfer, stall stability and period_done timing
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_stall = 1'b0;
            prev_tlx   = 1'b0;
         end else begin
            chk("period_done", {31'd0, period_done}, {31'd0, prev_tlx});
            if (prev_stall) begin
               chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
               chk("stall_data", m_tdata, held_d);
               chk("stall_last", {31'd0, m_tlast}, {31'd0, held_l});
            end
            prev_stall = m_tvalid && !m_tready;
            held_d     = m_tdata;
            held_l     = m_tlast;
            prev_tlx   = m_tvalid && m_tready && m_tlast;
            if (period_done)
               n_pd++;
            if (m_tvalid && m_tready) begin
               if (q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_xfer: got %0h expected none", m_tdata);
               end else begin
                  e = q.pop_front();
                  chk("tdata", m_tdata, e.d);
                  chk("tlast", {31'd0, m_tlast}, {31'd0, e.l});
               end
               if (n_x == 0)
                  first_x = cyc;
               last_x = cyc;
               n_x++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(int a, logic [31:0] d);
      wr_addr = a[9:0];
      wr_data = d;
      wr_en   = 1'b1;
      tick();
      wr_en   = 1'b0;
      mdl[a]  = d;
   endtask

   task automatic expect_play(int len, int nper);
      exp_t e;
      for (int p = 0; p < nper; p++)
         for (int a = 0; a <= len; a++) begin
            e.d = mdl[a];
            e.l = (a == len);
            q.push_back(e);
         end
   endtask

   task automatic go(int len, int num);
      len_m1      = len[9:0];
      num_periods = num[15:0];
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic wait_idle(string name, int max);
      int k = 0;
      while (busy && k < max) begin
         tick();
         k++;
      end
      chk(name, {31'd0, busy}, 32'd0);
      chk({name, "_queue"}, q.size(), 32'd0);
   endtask

   task automatic clr();
      n_x  = 0;
      n_pd = 0;
   endtask

   initial begin
      int len;
      int num;
      int k;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      len_m1 = '0; num_periods = '0; start = 1'b0; stop = 1'b0;
      #12;
      chk("rst_valid", {31'd0, m_tvalid}, 32'd0);
      chk("rst_last", {31'd0, m_tlast}, 32'd0);
      chk("rst_data", m_tdata, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_pd", {31'd0, period_done}, 32'd0);
      tick();
      #1 rst = 1'b0;
      tick();
      for (int a = 0; a < 4; a++)
         load(a, 32'hA0 + a);

      // Basic two-period playback, latency and gap-free check
      clr();
      expect_play(3, 2);
      go(3, 2);
      chk("lat0_valid", {31'd0, m_tvalid}, 32'd0);
      chk("busy_run", {31'd0, busy}, 32'd1);
      tick();
      chk("lat1_valid", {31'd0, m_tvalid}, 32'd0);
      tick();
      chk("lat2_valid", {31'd0, m_tvalid}, 32'd0);
      tick();
      chk("lat3_valid", {31'd0, m_tvalid}, 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle("basic_idle", 100);
      chk("basic_count", n_x, 32'd8);
      chk("basic_gapfree", last_x - first_x, 32'd7);
      chk("basic_pd", n_pd, 32'd2);

      // start together with stop, and stop alone, in IDLE
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("startstop_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("stop_idle_busy", {31'd0, busy}, 32'd0);
      stop = 1'b0;

      // Random backpressure
      clr();
      rnd_rdy = 1'b1;
      expect_play(3, 2);
      go(3, 2);
      wait_idle("rnd_idle", 300);
      chk("rnd_count", n_x, 32'd8);
      rnd_rdy = 1'b0;
      tick();

      // Continuous playback stopped early in period 3
      for (int a = 4; a < 8; a++)
         load(a, $urandom);
      clr();
      expect_play(7, 3);
      go(7, 0);
      k = 0;
      while (n_pd < 2 && k < 200) begin
         tick();
         k++;
      end
      chk("stop_reach_p3", {31'd0, n_pd >= 2}, 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("stop_idle", 200);
      chk("stop_valid", {31'd0, m_tvalid}, 32'd0);
      chk("stop_count", n_x, 32'd24);

      // One-sample periods
      clr();
      expect_play(0, 3);
      go(0, 3);
      wait_idle("len0_idle", 100);
      chk("len0_count", n_x, 32'd3);
      chk("len0_pd", n_pd, 32'd3);

      // Randomized periods, data and backpressure
      for (int it = 0; it < 4; it++) begin
         len = $urandom_range(1, 15);
         num = $urandom_range(1, 3);
         for (int a = 0; a <= len; a++)
            load(a, $urandom);
         clr();
         rnd_rdy = 1'b1;
         expect_play(len, num);
         go(len, num);
         wait_idle("rand_idle", 1000);
         chk("rand_count", n_x, (len + 1) * num);
         chk("rand_pd", n_pd, num);
         rnd_rdy = 1'b0;
         tick();
      end

      // Writes during playback are ignored
      for (int a = 0; a < 4; a++)
         load(a, 32'hA0 + a);
      clr();
      expect_play(3, 2);
      go(3, 2);
      wr_addr = '0;
      wr_data = 32'hFF;
      wr_en   = 1'b1;
      tick();
      wr_en   = 1'b0;
      wait_idle("wr_busy_idle", 100);

      // Reset mid-stream
      expect_play(3, 2);
      go(3, 2);
      repeat (5) tick();
      #2 rst = 1'b1;
      q.delete();
      #1;
      chk("midrst_valid", {31'd0, m_tvalid}, 32'd0);
      chk("midrst_last", {31'd0, m_tlast}, 32'd0);
      chk("midrst_data", m_tdata, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_pd", {31'd0, period_done}, 32'd0);
      tick();
      tick();
      #1 rst = 1'b0;
      tick();
      clr();
      expect_play(3, 1);
      go(3, 1);
      wait_idle("post_rst_idle", 100);
      chk("post_rst_count", n_x, 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
